// File: rtl/agc_serial_input.sv
// Serial front end for the AGC input-data buses: 8N1 UART bytes are assembled into
// 3-byte frames (header, data high, data low) that update one of seven held registers.
module agc_serial_input #(
   parameter int unsigned CLKS_PER_BIT  = 16,
   parameter int unsigned FRAME_TIMEOUT = 4096
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        serial_rx,
   output logic [14:0] DSKY_VERB_data,
   output logic [14:0] DSKY_NOUN_data,
   output logic [14:0] AXI_G_data,
   output logic [14:0] AXI_M_data,
   output logic [14:0] AXI_RA_data,
   output logic [14:0] AXI_RB_data,
   output logic [14:0] AXI_ATX_data,
   output logic        upd_valid,
   output logic [2:0]  upd_sel,
   output logic        frame_err
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned TmoW = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [CntW-1:0] BitCnt  = CntW'(CLKS_PER_BIT);
   localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(FRAME_TIMEOUT - 1);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [1:0] {FHdr, FHi, FLo} fr_state_e;

   rx_state_e       rx_q, rx_d;
   fr_state_e       fr_q, fr_d;
   logic            sync1_q, rx_s_q, rx_prev_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      sel_q, sel_d;
   logic [6:0]      hi_q, hi_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [14:0]     data_q [7];
   logic            upd_valid_q, frame_err_q;
   logic [2:0]      upd_sel_q;
   logic            start_edge, byte_done, byte_err, wr_en, err;

   // Synchronizer and edge history idle high so reset never looks like a start edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= serial_rx;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
      end
   end

   assign start_edge = (rx_q == RxIdle) && rx_prev_q && !rx_s_q;

   always_comb begin
      rx_d      = rx_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      byte_done = 1'b0;
      byte_err  = 1'b0;
      unique case (rx_q)
         RxIdle: begin
            if (start_edge) begin
               cnt_d = CntW'(1);
               rx_d  = RxStart;
            end
         end
         RxStart: begin
            if (cnt_q == HalfCnt) begin
               cnt_d = CntW'(1);
               bit_d = '0;
               rx_d  = rx_s_q ? RxIdle : RxData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (cnt_q == BitCnt) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               cnt_d   = CntW'(1);
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) rx_d = RxStop;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RxStop: begin
            if (cnt_q == BitCnt) begin
               byte_done = rx_s_q;
               byte_err  = !rx_s_q;
               rx_d      = RxIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: rx_d = RxIdle;
      endcase
   end

   // Timeout only advances while the line is quiet between bytes of a partial frame.
   always_comb begin
      fr_d  = fr_q;
      sel_d = sel_q;
      hi_d  = hi_q;
      tmo_d = tmo_q;
      wr_en = 1'b0;
      err   = 1'b0;
      if (start_edge || byte_done) begin
         tmo_d = '0;
      end else if (fr_q != FHdr && rx_q == RxIdle) begin
         if (tmo_q == TmoLast) begin
            err   = 1'b1;
            fr_d  = FHdr;
            tmo_d = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
      if (byte_err) begin
         err  = 1'b1;
         fr_d = FHdr;
      end else if (byte_done) begin
         unique case (fr_q)
            FHdr: begin
               if (shift_q[7:5] == 3'b101 && shift_q[2:0] != 3'b111) begin
                  sel_d = shift_q[2:0];
                  fr_d  = FHi;
               end else begin
                  err = 1'b1;
               end
            end
            FHi: begin
               if (shift_q[7]) begin
                  err  = 1'b1;
                  fr_d = FHdr;
               end else begin
                  hi_d = shift_q[6:0];
                  fr_d = FLo;
               end
            end
            FLo: begin
               wr_en = 1'b1;
               fr_d  = FHdr;
            end
            default: fr_d = FHdr;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_q        <= RxIdle;
         fr_q        <= FHdr;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         sel_q       <= '0;
         hi_q        <= '0;
         tmo_q       <= '0;
         upd_valid_q <= 1'b0;
         upd_sel_q   <= '0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < 7; i++) data_q[i] <= '0;
      end else begin
         rx_q        <= rx_d;
         fr_q        <= fr_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         sel_q       <= sel_d;
         hi_q        <= hi_d;
         tmo_q       <= tmo_d;
         upd_valid_q <= wr_en;
         frame_err_q <= err;
         if (wr_en) upd_sel_q <= sel_q;
         for (int i = 0; i < 7; i++) begin
            if (wr_en && sel_q == 3'(i)) data_q[i] <= {hi_q, shift_q};
         end
      end
   end

   assign DSKY_VERB_data = data_q[0];
   assign DSKY_NOUN_data = data_q[1];
   assign AXI_G_data     = data_q[2];
   assign AXI_M_data     = data_q[3];
   assign AXI_RA_data    = data_q[4];
   assign AXI_RB_data    = data_q[5];
   assign AXI_ATX_data   = data_q[6];
   assign upd_valid      = upd_valid_q;
   assign upd_sel        = upd_sel_q;
   assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_agc_serial_input.sv
// Bench for agc_serial_input: directed frames plus random frames, with expected register
// contents and event cycles derived from the bit timing of each transmitted byte.
module tb_agc_serial_input;

   localparam int unsigned CLKS = 16;
   localparam int unsigned TMO  = 4096;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        serial_rx = 1'b1;
   logic [14:0] verb, noun, g, m, ra, rb, atx;
   logic        upd_valid, frame_err;
   logic [2:0]  upd_sel;

   agc_serial_input #(.CLKS_PER_BIT(CLKS), .FRAME_TIMEOUT(TMO)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .serial_rx      (serial_rx),
      .DSKY_VERB_data (verb),
      .DSKY_NOUN_data (noun),
      .AXI_G_data     (g),
      .AXI_M_data     (m),
      .AXI_RA_data    (ra),
      .AXI_RB_data    (rb),
      .AXI_ATX_data   (atx),
      .upd_valid      (upd_valid),
      .upd_sel        (upd_sel),
      .frame_err      (frame_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int          upd_cyc[$], upd_sl[$], err_cyc[$];
   logic [14:0] upd_val[$];
   int          exp_upd_cyc[$], exp_upd_sel[$], exp_err_cyc[$];
   logic [14:0] exp_upd_val[$];
   logic [14:0] exp_reg[7];
   int          n_cmp = 0, n_bad = 0, overlap = 0;

   function automatic logic [14:0] out_of(input int i);
      case (i)
         0: return verb;
         1: return noun;
         2: return g;
         3: return m;
         4: return ra;
         5: return rb;
         6: return atx;
         default: return 'x;
      endcase
   endfunction

   always @(negedge clock) begin
      if (reset_n) begin
         if (upd_valid) begin
            upd_cyc.push_back(cyc);
            upd_sl.push_back(int'(upd_sel));
            upd_val.push_back(out_of(int'(upd_sel)));
         end
         if (frame_err) err_cyc.push_back(cyc);
         if (upd_valid && frame_err) overlap++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns the cycle on which the stop-bit outcome becomes visible on the outputs:
   // 2 synchronizer cycles, half a start bit, 9 full bits, then one register stage.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int vis);
      @(posedge clock);
      #1;
      vis = cyc + 2 + int'(CLKS / 2) + 9 * int'(CLKS) + 1;
      for (int k = 0; k < 10; k++) begin
         serial_rx = (k == 0) ? 1'b0 : (k == 9) ? stop_bit : b[k-1];
         repeat (CLKS) @(posedge clock);
         #1;
      end
      serial_rx = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] h, input logic [7:0] hi, input logic [7:0] lo,
                             output int vis);
      int v;
      send_byte(h, 1'b1, v);
      send_byte(hi, 1'b1, v);
      send_byte(lo, 1'b1, vis);
   endtask

   task automatic expect_write(input int sel, input logic [14:0] val, input int vis);
      exp_upd_cyc.push_back(vis);
      exp_upd_sel.push_back(sel);
      exp_upd_val.push_back(val);
      exp_reg[sel] = val;
   endtask

   task automatic settle_and_check(input string tag);
      int n;
      repeat (40) @(posedge clock);
      #1;
      chk($sformatf("%s_nupd", tag), upd_cyc.size(), exp_upd_cyc.size());
      n = (upd_cyc.size() < exp_upd_cyc.size()) ? upd_cyc.size() : exp_upd_cyc.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_upd%0d_cyc", tag, i), upd_cyc[i], exp_upd_cyc[i]);
         chk($sformatf("%s_upd%0d_sel", tag, i), upd_sl[i], exp_upd_sel[i]);
         chk($sformatf("%s_upd%0d_val", tag, i), 32'(upd_val[i]), 32'(exp_upd_val[i]));
      end
      chk($sformatf("%s_nerr", tag), err_cyc.size(), exp_err_cyc.size());
      n = (err_cyc.size() < exp_err_cyc.size()) ? err_cyc.size() : exp_err_cyc.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_err%0d_cyc", tag, i), err_cyc[i], exp_err_cyc[i]);
      for (int r = 0; r < 7; r++) chk($sformatf("%s_reg%0d", tag, r), 32'(out_of(r)), 32'(exp_reg[r]));
      upd_cyc.delete(); upd_sl.delete(); upd_val.delete(); err_cyc.delete();
      exp_upd_cyc.delete(); exp_upd_sel.delete(); exp_upd_val.delete(); exp_err_cyc.delete();
   endtask

   task automatic check_reset_state(input string tag);
      for (int r = 0; r < 7; r++) chk($sformatf("%s_reg%0d", tag, r), 32'(out_of(r)), 32'd0);
      chk($sformatf("%s_upd_valid", tag), 32'(upd_valid), 32'd0);
      chk($sformatf("%s_upd_sel", tag), 32'(upd_sel), 32'd0);
      chk($sformatf("%s_frame_err", tag), 32'(frame_err), 32'd0);
   endtask

   initial begin
      int          v1, v2, v3, sel, kind;
      logic [7:0]  h;
      logic [14:0] val;

      for (int r = 0; r < 7; r++) exp_reg[r] = '0;
      repeat (4) @(posedge clock);
      #1;
      check_reset_state("reset");
      reset_n = 1'b1;
      repeat (10) @(posedge clock);

      send_frame(8'hA0, 8'h00, 8'h25, v3);
      expect_write(0, 15'd37, v3);
      settle_and_check("verb");

      send_frame(8'hA2, 8'h14, 8'h83, v3);
      expect_write(2, 15'b001010010000011, v3);
      send_frame(8'hA1, 8'h00, 8'h05, v3);
      expect_write(1, 15'd5, v3);
      settle_and_check("g_noun");

      send_byte(8'hA7, 1'b1, v1);
      exp_err_cyc.push_back(v1);
      send_byte(8'hC0, 1'b1, v1);
      exp_err_cyc.push_back(v1);
      send_frame(8'hA4, 8'h7C, 8'h02, v3);
      expect_write(4, 15'b111110000000010, v3);
      settle_and_check("bad_hdr");

      send_byte(8'hA3, 1'b1, v1);
      send_byte(8'h55, 1'b0, v2);
      exp_err_cyc.push_back(v2);
      send_byte(8'h00, 1'b1, v3);
      exp_err_cyc.push_back(v3);
      settle_and_check("bad_stop");

      send_byte(8'hA5, 1'b1, v1);
      send_byte(8'h01, 1'b1, v2);
      exp_err_cyc.push_back(v2 + int'(TMO));
      repeat (5000) @(posedge clock);
      send_byte(8'hFF, 1'b1, v3);
      exp_err_cyc.push_back(v3);
      settle_and_check("timeout");

      for (int it = 0; it < 12; it++) begin
         kind = int'($urandom_range(0, 3));
         sel  = int'($urandom_range(0, 6));
         val  = 15'($urandom);
         h    = {3'b101, 2'($urandom_range(0, 3)), 3'(sel)};
         if (kind <= 1) begin
            send_frame(h, {1'b0, val[14:8]}, val[7:0], v3);
            expect_write(sel, val, v3);
         end else if (kind == 2) begin
            do h = 8'($urandom_range(0, 255));
            while (h[7:5] == 3'b101 && h[2:0] != 3'b111);
            send_byte(h, 1'b1, v1);
            exp_err_cyc.push_back(v1);
         end else begin
            send_byte(h, 1'b1, v1);
            send_byte(8'h80 | 8'($urandom_range(0, 127)), 1'b1, v2);
            exp_err_cyc.push_back(v2);
         end
         settle_and_check($sformatf("rand%0d", it));
      end

      @(posedge clock);
      #1;
      serial_rx = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      serial_rx = 1'b1;
      settle_and_check("glitch");

      send_byte(8'hA6, 1'b1, v1);
      @(posedge clock);
      #1;
      serial_rx = 1'b0;
      repeat (3 * CLKS) @(posedge clock);
      #1;
      reset_n   = 1'b0;
      serial_rx = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_reset_state("midrst");
      for (int r = 0; r < 7; r++) exp_reg[r] = '0;
      reset_n = 1'b1;
      settle_and_check("after_rst");

      send_frame(8'hA6, 8'h12, 8'h34, v3);
      expect_write(6, 15'h1234, v3);
      settle_and_check("atx");

      chk("no_overlap", overlap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
